// File: rtl/cache_nway.sv
// Set-associative write-back/write-allocate cache with round-robin replacement between processor and word-burst RAM.
// Latency: hit answers one cycle after the sample edge; miss adds a W-word fill burst, plus a W-word write-back if the victim is dirty.
// Backpressure: processor holds its request until ProzessorBereit; RAM bursts stall while RAMBereit is low, with all RAM outputs held.
module cache_nway #(
    parameter int CACHESIZEBITS = 15,
    parameter int BLOCKSIZEBITS = 5,
    parameter int NBITS         = 1
) (
    input  logic        Takt,
    input  logic        Reset_n,
    input  logic        ProzessorAnfrage,
    input  logic [31:0] ProzessorAdresse,
    input  logic        ProzessorSchreiben,
    input  logic [31:0] ProzessorSchreibDaten,
    output logic [31:0] ProzessorLesDaten,
    output logic        ProzessorBereit,
    output logic        RAMAnfrage,
    output logic [31:0] RAMAdresse,
    output logic        RAMSchreiben,
    output logic [31:0] RAMSchreibDaten,
    input  logic [31:0] RAMLesDaten,
    input  logic        RAMBereit
);

    localparam int SETNUMBITS = CACHESIZEBITS - BLOCKSIZEBITS - NBITS;
    localparam int WAYS       = 1 << NBITS;
    localparam int W          = 1 << (BLOCKSIZEBITS - 2);
    localparam int TAGW       = 32 - SETNUMBITS - BLOCKSIZEBITS;
    // Degenerate fields (direct-mapped, one set, one-word blocks) keep a 1-bit
    // stand-in field that is always zero so every index stays a plain concatenation.
    localparam int RRW        = (NBITS > 0) ? NBITS : 1;
    localparam int SW         = (SETNUMBITS > 0) ? SETNUMBITS : 1;
    localparam int OW         = (BLOCKSIZEBITS > 2) ? BLOCKSIZEBITS - 2 : 1;
    localparam int LW         = RRW + SW;
    localparam int DW         = LW + OW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       cnt_q, cnt_d;
    logic [RRW-1:0]      vic_q, vic_d;
    logic [31:0]         p_rdata_q, p_rdata_d;
    logic                p_rdy_q, p_rdy_d;
    logic                ram_req_q, ram_req_d;
    logic [31:0]         ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic [(1<<LW)-1:0]  valid_q, valid_d;
    logic [(1<<LW)-1:0]  dirty_q, dirty_d;
    logic [RRW-1:0]      rr_q [1<<SW];
    logic [RRW-1:0]      rr_d;
    logic                rr_we;

    logic [31:0]         data_mem [1<<DW];
    logic [TAGW-1:0]     tag_mem  [1<<LW];
    logic                dm_we;
    logic [DW-1:0]       dm_idx;
    logic [31:0]         dm_wdata;
    logic                tm_we;

    logic [TAGW-1:0]     req_tag;
    logic [SW-1:0]       req_set;
    logic [OW-1:0]       req_word;
    logic                hit;
    logic [RRW-1:0]      hit_way;
    logic [RRW-1:0]      vic_sel;
    logic                cnt_last;
    logic [OW-1:0]       cnt_nxt;
    logic                ram_done;
    logic                addr_lsb_unused;

    assign req_tag         = ProzessorAdresse[31 -: TAGW];
    assign addr_lsb_unused = ^ProzessorAdresse[1:0];
    assign cnt_last        = (cnt_q == OW'(W - 1));
    assign cnt_nxt         = cnt_q + OW'(1);
    assign ram_done        = ram_req_q && RAMBereit;

    generate
        if (SETNUMBITS > 0) begin : g_set
            assign req_set = ProzessorAdresse[BLOCKSIZEBITS +: SETNUMBITS];
        end else begin : g_noset
            assign req_set = '0;
        end
        if (BLOCKSIZEBITS > 2) begin : g_word
            assign req_word = ProzessorAdresse[2 +: OW];
        end else begin : g_noword
            assign req_word = '0;
        end
    endgenerate

    // Rebuild a word-aligned RAM byte address from tag, set and word index.
    function automatic logic [31:0] make_addr(input logic [TAGW-1:0] t,
                                              input logic [SW-1:0]   s,
                                              input logic [OW-1:0]   w);
        logic [31:0] a;
        a = {t, {(32 - TAGW){1'b0}}};
        a = a | ({{(32 - SW){1'b0}}, s} << BLOCKSIZEBITS);
        a = a | ({{(32 - OW){1'b0}}, w} << 2);
        return a;
    endfunction

    // Tag compare across the set, and victim choice: lowest invalid way, else the round-robin way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_sel = rr_q[req_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[{RRW'(w), req_set}]) vic_sel = RRW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[{RRW'(w), req_set}] && (tag_mem[{RRW'(w), req_set}] == req_tag)) begin
                hit     = 1'b1;
                hit_way = RRW'(w);
            end
        end
    end

    // Controller: next state, registered outputs and array updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vic_d       = vic_q;
        p_rdata_d   = p_rdata_q;
        p_rdy_d     = 1'b0;
        ram_req_d   = ram_req_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rr_we       = 1'b0;
        rr_d        = '0;
        dm_we       = 1'b0;
        dm_idx      = '0;
        dm_wdata    = '0;
        tm_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ProzessorAnfrage) begin
                    if (hit) begin
                        state_d = RESPOND;
                        p_rdy_d = 1'b1;
                        if (ProzessorSchreiben) begin
                            dm_we                      = 1'b1;
                            dm_idx                     = {hit_way, req_set, req_word};
                            dm_wdata                   = ProzessorSchreibDaten;
                            dirty_d[{hit_way, req_set}] = 1'b1;
                        end else begin
                            p_rdata_d = data_mem[{hit_way, req_set, req_word}];
                        end
                    end else begin
                        vic_d     = vic_sel;
                        cnt_d     = '0;
                        ram_req_d = 1'b1;
                        if (valid_q[{vic_sel, req_set}] && dirty_q[{vic_sel, req_set}]) begin
                            state_d     = WRITEBACK;
                            ram_we_d    = 1'b1;
                            ram_addr_d  = make_addr(tag_mem[{vic_sel, req_set}], req_set, '0);
                            ram_wdata_d = data_mem[{vic_sel, req_set, {OW{1'b0}}}];
                        end else begin
                            state_d    = FILL;
                            ram_we_d   = 1'b0;
                            ram_addr_d = make_addr(req_tag, req_set, '0);
                        end
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            WRITEBACK: begin
                if (ram_done) begin
                    if (cnt_last) begin
                        // Fill burst follows back-to-back: request stays high.
                        dirty_d[{vic_q, req_set}] = 1'b0;
                        state_d    = FILL;
                        cnt_d      = '0;
                        ram_we_d   = 1'b0;
                        ram_addr_d = make_addr(req_tag, req_set, '0);
                    end else begin
                        cnt_d       = cnt_nxt;
                        ram_addr_d  = make_addr(tag_mem[{vic_q, req_set}], req_set, cnt_nxt);
                        ram_wdata_d = data_mem[{vic_q, req_set, cnt_nxt}];
                    end
                end
            end
            FILL: begin
                if (ram_done) begin
                    dm_we    = 1'b1;
                    dm_idx   = {vic_q, req_set, cnt_q};
                    dm_wdata = RAMLesDaten;
                    if (cnt_last) begin
                        // Block becomes valid only once complete; IDLE then re-looks it up as a hit.
                        tm_we                     = 1'b1;
                        valid_d[{vic_q, req_set}] = 1'b1;
                        dirty_d[{vic_q, req_set}] = 1'b0;
                        rr_we                     = 1'b1;
                        rr_d                      = (NBITS == 0) ? '0 : vic_q + RRW'(1);
                        state_d                   = IDLE;
                        ram_req_d                 = 1'b0;
                    end else begin
                        cnt_d      = cnt_nxt;
                        ram_addr_d = make_addr(req_tag, req_set, cnt_nxt);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge Takt or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vic_q       <= '0;
            p_rdata_q   <= '0;
            p_rdy_q     <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vic_q       <= vic_d;
            p_rdata_q   <= p_rdata_d;
            p_rdy_q     <= p_rdy_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    // Per-set round-robin pointers, cleared on reset.
    always_ff @(posedge Takt or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < (1 << SW); i++) rr_q[i] <= '0;
        end else if (rr_we) begin
            rr_q[req_set] <= rr_d;
        end
    end

    // Data and tag storage; contents are meaningless until the valid bit says otherwise.
    always_ff @(posedge Takt) begin
        if (dm_we) data_mem[dm_idx] <= dm_wdata;
        if (tm_we) tag_mem[{vic_q, req_set}] <= req_tag;
    end

    assign ProzessorLesDaten = p_rdata_q;
    assign ProzessorBereit   = p_rdy_q;
    assign RAMAnfrage        = ram_req_q;
    assign RAMAdresse        = ram_addr_q;
    assign RAMSchreiben      = ram_we_q;
    assign RAMSchreibDaten   = ram_wdata_q;

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: default 2-way instance against a behavioural cache/RAM model,
// plus a direct-mapped one-word-block instance for the parameter corner case.
module tb_cache_nway;

    localparam int CSB  = 15;
    localparam int BSB  = 5;
    localparam int NB   = 1;
    localparam int W    = 1 << (BSB - 2);
    localparam int WAYS = 1 << NB;
    localparam int SETS = 1 << (CSB - BSB - NB);
    localparam int TSH  = CSB - NB;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ram_op_t;

    logic        Takt = 1'b0;
    logic        Reset_n;
    logic        ProzessorAnfrage, ProzessorSchreiben, ProzessorBereit;
    logic [31:0] ProzessorAdresse, ProzessorSchreibDaten, ProzessorLesDaten;
    logic        RAMAnfrage, RAMSchreiben, RAMBereit;
    logic [31:0] RAMAdresse, RAMSchreibDaten, RAMLesDaten;

    logic        ProzessorAnfrage1, ProzessorSchreiben1, ProzessorBereit1;
    logic [31:0] ProzessorAdresse1, ProzessorSchreibDaten1, ProzessorLesDaten1;
    logic        RAMAnfrage1, RAMSchreiben1, RAMBereit1;
    logic [31:0] RAMAdresse1, RAMSchreibDaten1, RAMLesDaten1;

    int checks   = 0;
    int failures = 0;
    int nrd = 0, nwr = 0, n1_rd = 0, cyc = 0;
    bit stall_mode = 1'b0;
    logic [31:0] last1_addr = '0;

    ram_op_t     exp_q[$];
    logic [31:0] ram_mem [bit [31:0]];
    logic [31:0] m_ram   [bit [31:0]];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][W];
    int          m_rr    [SETS];

    cache_nway u0 (
        .Takt(Takt), .Reset_n(Reset_n),
        .ProzessorAnfrage(ProzessorAnfrage), .ProzessorAdresse(ProzessorAdresse),
        .ProzessorSchreiben(ProzessorSchreiben), .ProzessorSchreibDaten(ProzessorSchreibDaten),
        .ProzessorLesDaten(ProzessorLesDaten), .ProzessorBereit(ProzessorBereit),
        .RAMAnfrage(RAMAnfrage), .RAMAdresse(RAMAdresse), .RAMSchreiben(RAMSchreiben),
        .RAMSchreibDaten(RAMSchreibDaten), .RAMLesDaten(RAMLesDaten), .RAMBereit(RAMBereit)
    );

    cache_nway #(.CACHESIZEBITS(15), .BLOCKSIZEBITS(2), .NBITS(0)) u1 (
        .Takt(Takt), .Reset_n(Reset_n),
        .ProzessorAnfrage(ProzessorAnfrage1), .ProzessorAdresse(ProzessorAdresse1),
        .ProzessorSchreiben(ProzessorSchreiben1), .ProzessorSchreibDaten(ProzessorSchreibDaten1),
        .ProzessorLesDaten(ProzessorLesDaten1), .ProzessorBereit(ProzessorBereit1),
        .RAMAnfrage(RAMAnfrage1), .RAMAdresse(RAMAdresse1), .RAMSchreiben(RAMSchreiben1),
        .RAMSchreibDaten(RAMSchreibDaten1), .RAMLesDaten(RAMLesDaten1), .RAMBereit(RAMBereit1)
    );

    always #5 Takt = ~Takt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    // Reference cache: pushes the RAM operations the access must cause and
    // returns read data and zero-wait latency.
    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                output logic [31:0] rd, output int lat);
        int s, o, hw, v;
        int unsigned t;
        logic [31:0] ra;
        s   = int'((a >> BSB) % SETS);
        t   = a >> TSH;
        o   = int'((a >> 2) % W);
        hw  = -1;
        lat = 1;
        rd  = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (hw < 0) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = m_rr[s];
            lat = W + 2;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                lat += W;
                for (int i = 0; i < W; i++) begin
                    ra = (m_tag[s][v] << TSH) | (s << BSB) | (i << 2);
                    exp_q.push_back('{1'b1, ra, m_data[s][v][i]});
                    m_ram[ra] = m_data[s][v][i];
                end
            end
            for (int i = 0; i < W; i++) begin
                ra = (t << TSH) | (s << BSB) | (i << 2);
                exp_q.push_back('{1'b0, ra, 32'h0});
                m_data[s][v][i] = m_ram.exists(ra) ? m_ram[ra] : ra;
            end
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = t;
            m_rr[s]       = (v + 1) % WAYS;
            hw            = v;
        end
        if (wr) begin
            m_data[s][hw][o] = wd;
            m_dirty[s][hw]   = 1'b1;
        end else begin
            rd = m_data[s][hw][o];
        end
    endtask

    // RAM ready generator: tied high, or one pulse every 5th cycle in stall mode.
    initial begin
        RAMBereit  = 1'b1;
        RAMBereit1 = 1'b1;
        forever begin
            @(posedge Takt);
            #1;
            cyc++;
            RAMBereit = stall_mode ? (cyc % 5 == 0) : 1'b1;
        end
    end

    // RAM model and RAM-side compare for the default instance.
    initial begin
        bit prev_req, prev_done;
        logic [31:0] pa, pd;
        logic pw;
        ram_op_t op;
        prev_req = 1'b0; prev_done = 1'b0; pa = '0; pd = '0; pw = 1'b0;
        RAMLesDaten = '0;
        forever begin
            @(negedge Takt);
            if (Reset_n && RAMAnfrage) begin
                if (prev_req && !prev_done) begin
                    chk("ram_addr_stable",  RAMAdresse, pa);
                    chk("ram_we_stable",    32'(RAMSchreiben), 32'(pw));
                    chk("ram_wdata_stable", RAMSchreibDaten, pd);
                end
                RAMLesDaten = ram_mem.exists(RAMAdresse) ? ram_mem[RAMAdresse] : RAMAdresse;
                if (RAMBereit) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ram_op actual=unexpected_op_at_0x%08h required=no_op", RAMAdresse);
                    end else begin
                        op = exp_q.pop_front();
                        chk("ram_we",   32'(RAMSchreiben), 32'(op.we));
                        chk("ram_addr", RAMAdresse, op.addr);
                        if (op.we) chk("ram_wdata", RAMSchreibDaten, op.data);
                    end
                    if (RAMSchreiben) begin
                        ram_mem[RAMAdresse] = RAMSchreibDaten;
                        nwr++;
                    end else begin
                        nrd++;
                    end
                end
            end
            prev_req  = Reset_n && RAMAnfrage;
            prev_done = RAMBereit;
            pa = RAMAdresse; pd = RAMSchreibDaten; pw = RAMSchreiben;
        end
    end

    // RAM model for the direct-mapped instance: returns address as data.
    initial begin
        RAMLesDaten1 = '0;
        forever begin
            @(negedge Takt);
            if (Reset_n && RAMAnfrage1) begin
                RAMLesDaten1 = RAMAdresse1;
                if (RAMBereit1) begin
                    n1_rd++;
                    last1_addr = RAMAdresse1;
                end
            end
        end
    end

    // One processor access on the default instance, checked against the model.
    task automatic access0(input string nm, input logic [31:0] a, input bit wr,
                           input logic [31:0] wd, input bit chk_lat, output logic [31:0] rd_out);
        logic [31:0] exp_rd;
        int exp_lat, n;
        bit seen;
        model_access(a, wr, wd, exp_rd, exp_lat);
        ProzessorAnfrage      = 1'b1;
        ProzessorAdresse      = a;
        ProzessorSchreiben    = wr;
        ProzessorSchreibDaten = wd;
        @(posedge Takt);
        n = 0; seen = 1'b0;
        while (!seen && n < 600) begin
            @(negedge Takt);
            n++;
            if (ProzessorBereit) seen = 1'b1;
        end
        rd_out = ProzessorLesDaten;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_bereit required=bereit_within_600", nm);
        end else begin
            if (chk_lat) chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
            if (!wr) chk({nm, "_rdata"}, ProzessorLesDaten, exp_rd);
            chk({nm, "_ram_ops_left"}, 32'(exp_q.size()), 32'd0);
        end
        exp_q.delete();
        @(posedge Takt);
        #1;
        ProzessorAnfrage = 1'b0;
        @(negedge Takt);
        chk({nm, "_bereit_one_cycle"}, 32'(ProzessorBereit), 32'd0);
        @(posedge Takt);
        #1;
    endtask

    // One read on the direct-mapped instance: must miss and fetch exactly one word.
    task automatic access1(input string nm, input logic [31:0] a);
        int base, n;
        bit seen;
        base = n1_rd;
        ProzessorAnfrage1  = 1'b1;
        ProzessorAdresse1  = a;
        ProzessorSchreiben1 = 1'b0;
        @(posedge Takt);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge Takt);
            n++;
            if (ProzessorBereit1) seen = 1'b1;
        end
        chk({nm, "_latency"}, 32'(n), 32'd3);
        chk({nm, "_rdata"}, ProzessorLesDaten1, a);
        chk({nm, "_fill_words"}, 32'(n1_rd - base), 32'd1);
        chk({nm, "_fill_addr"}, last1_addr, a);
        @(posedge Takt);
        #1;
        ProzessorAnfrage1 = 1'b0;
        @(posedge Takt);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, dummy;
        int b_rd, b_wr, n, lat;
        Reset_n = 1'b0;
        ProzessorAnfrage = 1'b0; ProzessorAdresse = '0; ProzessorSchreiben = 1'b0; ProzessorSchreibDaten = '0;
        ProzessorAnfrage1 = 1'b0; ProzessorAdresse1 = '0; ProzessorSchreiben1 = 1'b0; ProzessorSchreibDaten1 = '0;
        model_reset();
        repeat (3) @(posedge Takt);
        #1;
        chk("rst_lesdaten",   ProzessorLesDaten, 32'h0);
        chk("rst_bereit",     32'(ProzessorBereit), 32'h0);
        chk("rst_ramanfrage", 32'(RAMAnfrage), 32'h0);
        chk("rst_ramadresse", RAMAdresse, 32'h0);
        chk("rst_ramschr",    32'(RAMSchreiben), 32'h0);
        chk("rst_ramdaten",   RAMSchreibDaten, 32'h0);
        chk("rst_v_ramanfrage", 32'(RAMAnfrage1), 32'h0);
        Reset_n = 1'b1;
        @(posedge Takt);
        #1;

        // Cold read miss, then a hit in the same block.
        b_rd = nrd;
        access0("cold_miss", 32'h0000_0100, 1'b0, '0, 1'b1, rd);
        chk("cold_miss_literal", rd, 32'h0000_0100);
        chk("cold_miss_reads", 32'(nrd - b_rd), 32'd8);
        b_rd = nrd;
        access0("hit_104", 32'h0000_0104, 1'b0, '0, 1'b1, rd);
        chk("hit_104_literal", rd, 32'h0000_0104);
        chk("hit_104_no_ram", 32'(nrd - b_rd), 32'd0);

        // Dirty eviction in set 0.
        b_wr = nwr;
        access0("wr_0000", 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 1'b1, dummy);
        access0("rd_4000", 32'h0000_4000, 1'b0, '0, 1'b1, rd);
        chk("rd_4000_literal", rd, 32'h0000_4000);
        chk("no_wb_yet", 32'(nwr - b_wr), 32'd0);
        access0("rd_8000", 32'h0000_8000, 1'b0, '0, 1'b1, rd);
        chk("rd_8000_literal", rd, 32'h0000_8000);
        chk("dirty_wb_writes", 32'(nwr - b_wr), 32'd8);
        access0("rd_0000_back", 32'h0000_0000, 1'b0, '0, 1'b1, rd);
        chk("rd_0000_back_literal", rd, 32'hA5A5_A5A5);

        // Clean eviction in set 1: no RAM writes at all.
        b_wr = nwr;
        access0("clean_0020", 32'h0000_0020, 1'b0, '0, 1'b1, rd);
        access0("clean_4020", 32'h0000_4020, 1'b0, '0, 1'b1, rd);
        access0("clean_8020", 32'h0000_8024, 1'b0, '0, 1'b1, rd);
        chk("clean_8024_literal", rd, 32'h0000_8024);
        chk("clean_no_writes", 32'(nwr - b_wr), 32'd0);

        // Stalling RAM.
        stall_mode = 1'b1;
        b_rd = nrd;
        access0("stall_300", 32'h0000_0308, 1'b0, '0, 1'b0, rd);
        chk("stall_literal", rd, 32'h0000_0308);
        chk("stall_reads", 32'(nrd - b_rd), 32'd8);
        stall_mode = 1'b0;
        @(posedge Takt);
        #1;

        // Reset in the middle of a fill, after word 3 completes.
        b_rd = nrd;
        model_access(32'h0000_0200, 1'b0, '0, dummy, lat);
        ProzessorAnfrage = 1'b1; ProzessorAdresse = 32'h0000_0200; ProzessorSchreiben = 1'b0;
        n = 0;
        while (nrd < b_rd + 4 && n < 200) begin
            @(negedge Takt);
            #1;
            n++;
        end
        @(posedge Takt);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_words_done", 32'(nrd - b_rd), 32'd4);
        chk("midrst_ramanfrage", 32'(RAMAnfrage), 32'h0);
        chk("midrst_ramadresse", RAMAdresse, 32'h0);
        chk("midrst_ramschr",    32'(RAMSchreiben), 32'h0);
        chk("midrst_ramdaten",   RAMSchreibDaten, 32'h0);
        chk("midrst_bereit",     32'(ProzessorBereit), 32'h0);
        chk("midrst_lesdaten",   ProzessorLesDaten, 32'h0);
        exp_q.delete();
        model_reset();
        ProzessorAnfrage = 1'b0;
        @(posedge Takt);
        #1;
        Reset_n = 1'b1;
        @(posedge Takt);
        #1;
        b_rd = nrd;
        access0("refill_200", 32'h0000_0200, 1'b0, '0, 1'b1, rd);
        chk("refill_200_literal", rd, 32'h0000_0200);
        chk("refill_200_reads", 32'(nrd - b_rd), 32'd8);

        // Direct-mapped, one-word blocks: conflicting addresses always miss.
        access1("dm_0000_a", 32'h0000_0000);
        access1("dm_8000_a", 32'h0000_8000);
        access1("dm_0000_b", 32'h0000_0000);
        access1("dm_8000_b", 32'h0000_8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_nway.md
# cache_nway

N-way set-associative, write-back, write-allocate cache between the processor and the RAM. It is parametrised in total size, block size and associativity, and direct-mapped operation is the NBITS=0 special case. It adds a request/ready handshake on both sides, dirty-block write-back, and a per-set round-robin replacement policy. RAM transfers are word-sequential bursts.

## Interface
- CACHESIZEBITS, 15: log2 of cache capacity in bytes.
- BLOCKSIZEBITS, 5: log2 of block size in bytes, ≥2. W = 2^(BLOCKSIZEBITS-2) words per block.
- NBITS, 1: log2 of ways. SETNUMBITS = CACHESIZEBITS-BLOCKSIZEBITS-NBITS, ≥0.
- Takt  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ProzessorAnfrage  in  1  access request; held with address/data until ProzessorBereit.
- ProzessorAdresse  in  32  byte address; bits [1:0] ignored.
- ProzessorSchreiben  in  1  1 = word write, 0 = read.
- ProzessorSchreibDaten  in  32  write data.
- ProzessorLesDaten  out  32  read data, valid while ProzessorBereit=1.
- ProzessorBereit  out  1  one-cycle completion pulse.
- RAMAnfrage  out  1  RAM word request.
- RAMAdresse  out  32  word-aligned byte address.
- RAMSchreiben  out  1  1 = RAM write.
- RAMSchreibDaten  out  32  RAM write data.
- RAMLesDaten  in  32  RAM read data, valid with RAMBereit.
- RAMBereit  in  1  RAM completes the current word in this cycle.

## Operation
- Address split:
  - tag = [31 : SETNUMBITS+BLOCKSIZEBITS]
  - set = next SETNUMBITS bits
  - word offset = [BLOCKSIZEBITS-1 : 2]
- Per way/set state: valid, dirty, tag, W data words. Per set: round-robin pointer rr[NBITS-1:0].
- States: IDLE, RESPOND, WRITEBACK, FILL.
- IDLE: on ProzessorAnfrage=1, compare the tag against all ways of the set.
  - Hit, read: latch the word into ProzessorLesDaten, go to RESPOND.
  - Hit, write: write the word, set dirty, go to RESPOND.
  - Miss: select the victim. The victim is the lowest-index invalid way; if every way is valid, it is way rr.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to FILL.
- RESPOND: ProzessorBereit=1 for exactly one cycle, then IDLE. ProzessorAnfrage is ignored during RESPOND.
- WRITEBACK: W RAM writes, words 0..W-1 in order.
  - Address = {victim tag, set, word index, 2'b00}; data = victim word.
  - After the last word: clear dirty, go to FILL.
- FILL: W RAM reads, words 0..W-1 in order, at {request tag, set, word index, 2'b00}.
  - Each word is stored on its RAMBereit.
  - After the last word: tag←request tag, valid←1, dirty←0, rr←victim+1 (mod 2^NBITS), return to IDLE.
  - The re-lookup in IDLE then hits.
- rr advances only at fill completion. Hits do not touch rr.
- Writes are full 32-bit words; there are no byte enables.

## Timing
- Reset (asynchronous, Reset_n=0):
  - State→IDLE.
  - All valid, dirty and rr bits→0.
  - Outputs→0: ProzessorLesDaten, ProzessorBereit, RAMAnfrage, RAMAdresse, RAMSchreiben, RAMSchreibDaten.
  - Data and tag arrays are not reset.
- Reset mid-transfer abandons the burst, and RAMAnfrage drops immediately. A partially filled block stays invalid.
- All outputs are registered.
- Hit: request sampled at edge k; ProzessorBereit=1 in cycle k+1. A write hit updates the array at edge k.
- Throughput: at most one access per 2 cycles.
- RAM handshake:
  - RAMAnfrage stays high for the whole burst.
  - A word completes on each edge where RAMAnfrage=1 and RAMBereit=1.
  - Address, data and RAMSchreiben change only after a completion and stay stable during stalls.
  - RAMAnfrage falls in the cycle after the last word completes.
  - The WRITEBACK→FILL transition has no idle cycle between bursts.
- Miss latency with zero-wait RAM (RAMBereit tied 1):
  - Clean miss: W fill cycles + 1 IDLE re-lookup + 1 RESPOND. ProzessorBereit rises W+2 cycles after the sample edge.
  - Dirty miss: adds W cycles.
- RAMBereit while RAMAnfrage=0 is ignored.

## Test plan
- Cold read miss, defaults, RAM returns address as data. Read 0x00000100 → 8 reads at 0x100..0x11C, ProzessorLesDaten=0x100 with Bereit. Then read 0x00000104 → Bereit one cycle after the sample edge, data 0x104, no RAMAnfrage.
- Dirty eviction, defaults (set stride 0x4000):
  - Write 0xA5A5A5A5 to 0x0000 → fill into way0, rr=1.
  - Read 0x4000 → fill into way1, rr=0.
  - Read 0x8000 → 8 writes at 0x0000..0x001C, with word 0 = 0xA5A5A5A5. Then 8 reads from 0x8000.
- Clean eviction: same sequence with reads only → no RAMSchreiben=1 cycle; the third miss goes straight to FILL.
- RAM stalls: RAMBereit asserted every 5th cycle → RAMAdresse/RAMAnfrage stable in between, exactly W reads, one ProzessorBereit.
- Reset mid-fill after word 3: Reset_n low → all outputs 0 immediately. A re-read of the same address performs a full 8-word fill.
- Parameter variant NBITS=0, BLOCKSIZEBITS=2: 1-word fills. Alternating 0x0 / 0x8000 reads (CACHESIZEBITS=15) miss every time.
